// File: rtl/pio_write_arbiter.sv
// Two-requester round-robin arbiter issuing write/set/clear/toggle operations
// to an Avalon-MM PIO slave, keeping a shadow copy of the PIO output register.
//
// state | meaning
// IDLE  | waiting for a request; grant, op and data latched on exit
// WR    | single-cycle Avalon write strobe; shadow updated on exit
// ACK   | one-cycle ack to the granted requester
module pio_write_arbiter #(
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              req_b,
  input  logic [1:0]        op_a,
  input  logic [1:0]        op_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [31:0]       writedata,
  output logic [DATA_W-1:0] shadow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WR, ACK} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_TOG   = 2'b11;

  state_t            state;
  logic              prio_b;
  logic              gnt_b;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;

  logic              pick_b;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [2:0]        sel_addr;
  logic [31:0]       sel_wd;
  logic [DATA_W-1:0] shadow_nxt;

  // prio_b set means A was granted last, so B wins a tie
  assign pick_b   = req_b & (~req_a | prio_b);
  assign sel_op   = pick_b ? op_b : op_a;
  assign sel_data = pick_b ? data_b : data_a;

  always_comb begin
    sel_addr = 3'd0;
    sel_wd   = '0;
    case (sel_op)
      OP_WRITE: begin sel_addr = 3'd0; sel_wd[DATA_W-1:0] = sel_data;          end
      OP_SET:   begin sel_addr = 3'd4; sel_wd[DATA_W-1:0] = sel_data;          end
      OP_CLEAR: begin sel_addr = 3'd5; sel_wd[DATA_W-1:0] = sel_data;          end
      default:  begin sel_addr = 3'd0; sel_wd[DATA_W-1:0] = shadow ^ sel_data; end
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    case (op_q)
      OP_WRITE: shadow_nxt = data_q;
      OP_SET:   shadow_nxt = shadow | data_q;
      OP_CLEAR: shadow_nxt = shadow & ~data_q;
      OP_TOG:   shadow_nxt = shadow ^ data_q;
      default:  shadow_nxt = shadow;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio_b     <= 1'b0;
      gnt_b      <= 1'b0;
      op_q       <= OP_WRITE;
      data_q     <= '0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      address    <= 3'd0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= '0;
      shadow     <= RESET_VAL;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            gnt_b      <= pick_b;
            prio_b     <= ~pick_b;
            op_q       <= sel_op;
            data_q     <= sel_data;
            address    <= sel_addr;
            writedata  <= sel_wd;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            state      <= WR;
          end
        end
        WR: begin
          chipselect <= 1'b0;
          write_n    <= 1'b1;
          address    <= 3'd0;
          writedata  <= '0;
          shadow     <= shadow_nxt;
          ack_a      <= ~gnt_b;
          ack_b      <= gnt_b;
          state      <= ACK;
        end
        ACK: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_write_arbiter.sv
// Directed bench for pio_write_arbiter: write/set/clear/toggle, round-robin
// contention, mid-operation reset and idle quiescence.
module tb_pio_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req_a, req_b;
  logic [1:0]  op_a, op_b;
  logic [3:0]  data_a, data_b;
  logic        ack_a, ack_b;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  shadow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  pio_write_arbiter #(.DATA_W(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .req_b(req_b),
    .op_a(op_a), .op_b(op_b),
    .data_a(data_a), .data_b(data_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .shadow(shadow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation from a single requester; req drops after the grant edge
  task automatic do_op(input logic use_b, input logic [1:0] op, input logic [3:0] data,
                       input logic [2:0] exp_addr, input logic [31:0] exp_wd,
                       input logic [3:0] exp_shadow);
    if (use_b) begin req_b = 1'b1; op_b = op; data_b = data; end
    else       begin req_a = 1'b1; op_a = op; data_a = data; end
    tick();
    chk("wr_cs",      {31'd0, chipselect}, 32'd1);
    chk("wr_write_n", {31'd0, write_n},    32'd0);
    chk("wr_addr",    {29'd0, address},    {29'd0, exp_addr});
    chk("wr_data",    writedata,           exp_wd);
    chk("wr_busy",    {31'd0, busy},       32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    chk("ack_a",      {31'd0, ack_a},      {31'd0, ~use_b});
    chk("ack_b",      {31'd0, ack_b},      {31'd0, use_b});
    chk("ack_cs",     {31'd0, chipselect}, 32'd0);
    chk("ack_data",   writedata,           32'd0);
    chk("shadow",     {28'd0, shadow},     {28'd0, exp_shadow});
    tick();
    chk("idle_busy",  {31'd0, busy},       32'd0);
    chk("idle_acks",  {30'd0, ack_a, ack_b}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    op_a = 2'b00; op_b = 2'b00;
    data_a = 4'h0; data_b = 4'h0;
    tick();
    tick();
    chk("rst_busy",    {31'd0, busy},       32'd0);
    chk("rst_acks",    {30'd0, ack_a, ack_b}, 32'd0);
    chk("rst_cs",      {31'd0, chipselect}, 32'd0);
    chk("rst_write_n", {31'd0, write_n},    32'd1);
    chk("rst_addr",    {29'd0, address},    32'd0);
    chk("rst_data",    writedata,           32'd0);
    chk("rst_shadow",  {28'd0, shadow},     32'd0);
    reset = 1'b0;

    do_op(1'b0, 2'b00, 4'hA, 3'd0, 32'h0000000A, 4'hA);
    do_op(1'b1, 2'b01, 4'h5, 3'd4, 32'h00000005, 4'hF);

    // Both requesters held: A sets 0 (addr 4), B clears 0 (addr 5); last grant was B
    req_a = 1'b1; op_a = 2'b01; data_a = 4'h0;
    req_b = 1'b1; op_b = 2'b10; data_b = 4'h0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_cs",   {31'd0, chipselect}, 32'd1);
      chk("rr_addr", {29'd0, address},    (k % 2 == 0) ? 32'd4 : 32'd5);
      tick();
      chk("rr_ack_a",  {31'd0, ack_a},    (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_ack_b",  {31'd0, ack_b},    (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_overlap", {31'd0, ack_a & ack_b}, 32'd0);
      tick();
      chk("rr_idle", {31'd0, busy}, 32'd0);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("rr_shadow", {28'd0, shadow}, 32'hF);

    do_op(1'b0, 2'b10, 4'h3, 3'd5, 32'h00000003, 4'hC);
    do_op(1'b0, 2'b11, 4'h6, 3'd0, 32'h0000000A, 4'hA);

    // Reset in the middle of WR
    req_a = 1'b1; op_a = 2'b00; data_a = 4'h5;
    tick();
    chk("mr_cs_before", {31'd0, chipselect}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_cs",      {31'd0, chipselect}, 32'd0);
    chk("mr_write_n", {31'd0, write_n},    32'd1);
    chk("mr_addr",    {29'd0, address},    32'd0);
    chk("mr_data",    writedata,           32'd0);
    chk("mr_shadow",  {28'd0, shadow},     32'd0);
    chk("mr_busy",    {31'd0, busy},       32'd0);
    req_a = 1'b0;
    tick();
    chk("mr_no_ack", {30'd0, ack_a, ack_b}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mr_no_ack2", {30'd0, ack_a, ack_b}, 32'd0);
    chk("mr_idle",    {31'd0, busy},         32'd0);
    do_op(1'b0, 2'b00, 4'h3, 3'd0, 32'h00000003, 4'h3);

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_cs",      {31'd0, chipselect}, 32'd0);
      chk("idle_write_n", {31'd0, write_n},    32'd1);
      chk("idle_busy20",  {31'd0, busy},       32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_write_arbiter.md
PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 4: width of the PIO output field being driven.
REQ-002 Parameter RESET_VAL, default 0: shadow value after reset; must equal the PIO slave's reset value.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_a, req_b  input  1 each  operation request from requester A / B; held high until the matching ack.
REQ-006 op_a, op_b  input  2 each  operation code: 00 write, 01 set bits, 10 clear bits, 11 toggle bits.
REQ-007 data_a, data_b  input  DATA_W each  operand; must be stable while the matching req is high.
REQ-008 ack_a, ack_b  output  1 each  one-cycle completion pulse to requester A / B.
REQ-009 address  output  3  Avalon-MM master address to the PIO slave.
REQ-010 chipselect  output  1  Avalon-MM chip select, active high.
REQ-011 write_n  output  1  Avalon-MM write strobe, active low.
REQ-012 writedata  output  32  Avalon-MM write data; bits above DATA_W are driven 0.
REQ-013 shadow  output  DATA_W  mirror of the PIO output register contents.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, WR, ACK.
REQ-016 In IDLE, if any req is high, the arbiter SHALL latch the grant, op and data, and go to WR on the next edge; otherwise it stays in IDLE.
REQ-017 Arbitration SHALL be round-robin: if both req_a and req_b are high, grant goes to the requester not granted last; after reset, A has priority.
REQ-018 In WR, chipselect=1 and write_n=0 for exactly one cycle; the next state is ACK.
REQ-019 Op 00 SHALL issue address 0 with writedata=data.
REQ-020 Op 01 SHALL issue address 4 with writedata=data.
REQ-021 Op 10 SHALL issue address 5 with writedata=data.
REQ-022 Op 11 SHALL issue address 0 with writedata=shadow XOR data; shadow is sampled at grant time.
REQ-023 shadow SHALL update on the WR edge as follows: op 00 → data; op 01 → shadow|data; op 10 → shadow&~data; op 11 → shadow^data.
REQ-024 In ACK, the granted requester's ack SHALL be 1 for exactly one cycle; the next state is IDLE.
REQ-025 Latency: req sampled high in IDLE at edge N → write strobe during cycle N+1 → ack during cycle N+2 → IDLE at N+3.
REQ-026 Maximum throughput SHALL be one operation per 3 cycles.
REQ-027 A req falling before its ack SHALL NOT abort an operation already granted.
REQ-028 Outside WR, the outputs SHALL be chipselect=0, write_n=1, address=0 and writedata=0.
REQ-029 ack_a and ack_b SHALL never be high in the same cycle.
REQ-030 Ack SHALL only follow a completed write.
REQ-031 Requests arriving while busy SHALL wait; they are evaluated only in IDLE.

Reset
REQ-032 On reset assertion, independent of clk, the block SHALL immediately set:
- state = IDLE, busy = 0
- ack_a = ack_b = 0
- chipselect = 0, write_n = 1, address = 0, writedata = 0
- shadow = RESET_VAL
- round-robin pointer favouring A
REQ-033 Reset asserted during WR or ACK SHALL drop the operation with no ack issued; shadow returns to RESET_VAL.
REQ-034 After reset deasserts, the first edge SHALL evaluate requests normally.

Verification
REQ-035 Write: req_a, op=00, data=0xA → one strobe at address 0 with writedata=0x0000000A; ack_a two cycles after grant; shadow=0xA.
REQ-036 Set then clear: from shadow=0xA, set 0x5 → address 4, shadow=0xF; then clear 0x3 → address 5, shadow=0xC.
REQ-037 Toggle: from shadow=0xC, op=11 data=0x6 → address 0 with writedata=0x0000000A; shadow=0xA.
REQ-038 Contention: req_a and req_b both held high for 4 operations → grant sequence A,B,A,B; acks never overlap; 12 cycles total.
REQ-039 Mid-op reset: assert reset during WR → outputs return to reset values at once; no ack; shadow=0; the next req_a is served normally.
REQ-040 Idle check: no requests for 20 cycles → chipselect stays 0, write_n stays 1, busy stays 0.
